// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one memory bus between the CPU (primary owner) and a DMA/loader port.
// The CPU owns the bus by default. A waiting DMA requester is granted the bus
// only after the CPU has run for MAX_CPU_BURST cycles, and never in a CPU
// write cycle. A DMA tenure lasts at most DMA_MAX_LEN transfers. While DMA
// owns the bus the CPU is frozen through cpu_rdy.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   cpu_addr/dout/we       CPU bus request
//   cpu_din, cpu_rdy       CPU read data, CPU may advance
//   dma_req/addr/dout/we   DMA bus request (level, qualified by dma_req)
//   dma_gnt, dma_ack       DMA owns the bus, DMA transfer completes this cycle
//   dma_din                DMA read data
//   mem_addr/dout/we       muxed memory bus
//   mem_din                memory read data (combinational on mem_addr)
//   stall_count            debug: cycles spent with the CPU frozen (wraps)
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int MAX_CPU_BURST = 4,
  parameter int DMA_MAX_LEN   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_din,
  output logic              cpu_rdy,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_dout,
  input  logic              dma_we,
  output logic              dma_gnt,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_din,
  output logic [15:0]       stall_count
);

  localparam int SW = (MAX_CPU_BURST > 1) ? $clog2(MAX_CPU_BURST) : 1;
  localparam int LW = (DMA_MAX_LEN > 1) ? $clog2(DMA_MAX_LEN) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_CPU_BURST - 1);
  localparam logic [LW-1:0] LEN_MAX    = LW'(DMA_MAX_LEN - 1);

  typedef enum logic {
    CPU_OWN = 1'b0,
    DMA_OWN = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] starve_cnt, starve_cnt_n;
  logic [LW-1:0] dma_len, dma_len_n;

  // Decoded ownership outputs.
  assign cpu_rdy = (state == CPU_OWN);
  assign dma_gnt = (state == DMA_OWN);
  assign dma_ack = dma_gnt & dma_req;

  // Bus mux: the non-owner's write strobe is never forwarded.
  assign mem_addr = dma_gnt ? dma_addr : cpu_addr;
  assign mem_dout = dma_gnt ? dma_dout : cpu_dout;
  assign mem_we   = dma_gnt ? (dma_we & dma_req) : cpu_we;

  // Zero-latency read path to both requesters.
  assign cpu_din = mem_din;
  assign dma_din = mem_din;

  // NOTE: every always_comb target gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_n      = state;
    starve_cnt_n = starve_cnt;
    dma_len_n    = dma_len;
    unique case (state)
      CPU_OWN: begin
        dma_len_n = '0;
        if (!dma_req) begin
          starve_cnt_n = '0;
        end else if (starve_cnt == STARVE_MAX && !cpu_we) begin
          // A CPU write cycle is never preempted; hand over on a non-write.
          state_n      = DMA_OWN;
          starve_cnt_n = '0;
        end else if (starve_cnt != STARVE_MAX) begin
          starve_cnt_n = starve_cnt + SW'(1);
        end
      end
      DMA_OWN: begin
        // starve_cnt stays 0 so a still-pending request after a capped tenure
        // gives the CPU a full burst before the next grant.
        starve_cnt_n = '0;
        if (!dma_req) begin
          state_n   = CPU_OWN;
          dma_len_n = '0;
        end else if (dma_len == LEN_MAX) begin
          state_n   = CPU_OWN;
          dma_len_n = '0;
        end else begin
          dma_len_n = dma_len + LW'(1);
        end
      end
      default: state_n = CPU_OWN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= CPU_OWN;
      starve_cnt  <= '0;
      dma_len     <= '0;
      stall_count <= '0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_cnt_n;
      dma_len    <= dma_len_n;
      if (state == DMA_OWN) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter with default parameters
// (MAX_CPU_BURST=4, DMA_MAX_LEN=8). A small behavioural memory sits on the
// mem_* bus; the bench drives the CPU and DMA sides directly.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_we;
  logic        dma_gnt;
  logic        dma_ack;
  logic [7:0]  dma_din;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_we;
  logic [7:0]  mem_din;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:4095] = '{default: 8'h00};

  always #5 clk = ~clk;

  assign mem_din = mem[mem_addr[11:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:0]] <= mem_dout;

  mem_bus_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_we     (cpu_we),
    .cpu_din    (cpu_din),
    .cpu_rdy    (cpu_rdy),
    .dma_req    (dma_req),
    .dma_addr   (dma_addr),
    .dma_dout   (dma_dout),
    .dma_we     (dma_we),
    .dma_gnt    (dma_gnt),
    .dma_ack    (dma_ack),
    .dma_din    (dma_din),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_we     (mem_we),
    .mem_din    (mem_din),
    .stall_count(stall_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          errs;
  int          acks;
  int          ncyc;
  int          first_acks;
  int          w;
  logic        ack;
  logic        in_first;
  logic [7:0]  a_reg;
  logic [63:0] pattern;
  logic [7:0]  rom [0:4];

  initial begin
    rom[0] = 8'hA9; rom[1] = 8'h03; rom[2] = 8'h69; rom[3] = 8'h04; rom[4] = 8'hEA;
    reset = 1'b1;
    cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_we = 1'b0;
    dma_req = 1'b0; dma_addr = 16'h0FFF; dma_dout = 8'h00; dma_we = 1'b0;
    step();
    step();

    // Reset state.
    check("rst_cpu_rdy", cpu_rdy, 1);
    check("rst_dma_gnt", dma_gnt, 0);
    check("rst_dma_ack", dma_ack, 0);
    check("rst_stall", stall_count, 0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    reset = 1'b0;

    // Load the ROM image through the CPU write path.
    for (int i = 0; i < 5; i++) begin
      cpu_addr = 16'(i); cpu_dout = rom[i]; cpu_we = 1'b1;
      step();
    end
    cpu_we = 1'b0;

    // Idle DMA: LDA #3 / ADC #4 then NOPs for 200 cycles.
    errs = 0; a_reg = 8'h00;
    for (int i = 0; i < 200; i++) begin
      cpu_addr = (i < 4) ? 16'(i) : 16'h0004;
      #1;
      if (!cpu_rdy || dma_gnt || mem_addr !== cpu_addr || mem_we) errs++;
      if (i == 1) a_reg = cpu_din;
      if (i == 3) a_reg = a_reg + cpu_din;
      step();
    end
    check("idle_bus_errs", errs, 0);
    check("idle_acc", a_reg, 8'h07);
    check("idle_stall", stall_count, 0);

    // Grant latency: req rises, four CPU cycles, then grant.
    dma_req = 1'b1; dma_addr = 16'h0300; dma_we = 1'b0; cpu_addr = 16'h0004;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (dma_gnt || !cpu_rdy) errs++;
      step();
    end
    #1;
    check("lat_early_gnt", errs, 0);
    check("lat_gnt", dma_gnt, 1);
    check("lat_rdy", cpu_rdy, 0);
    check("lat_mem_addr", mem_addr, 16'h0300);
    check("lat_ack", dma_ack, 1);
    check("lat_no_we", mem_we, 0);
    step();
    dma_req = 1'b0;
    #1;
    check("lat_idle_ack", dma_ack, 0);
    step();
    check("lat_release", cpu_rdy, 1);
    check("lat_stall", stall_count, 2);

    // Capped tenure: DMA writes 0xA5 to 0x0200..0x0209.
    dma_req = 1'b1; dma_we = 1'b1; dma_dout = 8'hA5; dma_addr = 16'h0200;
    ncyc = 0; pattern = '0; first_acks = 0; in_first = 1'b1;
    while (dma_addr != 16'h020A && ncyc < 60) begin
      #1;
      pattern[ncyc] = dma_gnt;
      ack = dma_ack;
      if (in_first && ncyc > 4 && !dma_gnt) in_first = 1'b0;
      if (ack && in_first) first_acks++;
      step();
      ncyc++;
      if (ack) dma_addr = dma_addr + 16'd1;
    end
    check("cap_cycles", ncyc, 18);
    check("cap_gnt_pattern", pattern, 64'h30FF0);
    check("cap_first_acks", first_acks, 8);
    check("cap_stall", stall_count, 12);
    check("cap_mem_200", mem[12'h200], 8'hA5);
    check("cap_mem_207", mem[12'h207], 8'hA5);
    check("cap_mem_209", mem[12'h209], 8'hA5);
    check("cap_mem_20a", mem[12'h20A], 8'h00);
    dma_req = 1'b0;
    step();
    check("cap_release", cpu_rdy, 1);

    // Write protection: CPU writes while starve_cnt is saturated.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0400; dma_dout = 8'h5A;
    errs = 0;
    for (int s = 0; s < 6; s++) begin
      if (s == 3 || s == 4) begin
        cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_dout = 8'h77;
      end else begin
        cpu_we = 1'b0; cpu_addr = 16'h0020;
      end
      #1;
      if (mem_we !== cpu_we || dma_gnt || mem_addr !== cpu_addr) errs++;
      step();
    end
    cpu_we = 1'b0;
    #1;
    check("wp_cpu_own_errs", errs, 0);
    check("wp_gnt", dma_gnt, 1);
    check("wp_cpu_write", mem[12'h010], 8'h77);
    check("wp_no_dma_write", mem[12'h400], 8'h00);

    // Early release after three acks.
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) #1;
      if (dma_ack) acks++;
      step();
      dma_addr = dma_addr + 16'd1;
    end
    dma_req = 1'b0;
    #1;
    check("er_acks", acks, 3);
    check("er_idle_gnt", dma_gnt, 1);
    check("er_idle_we", mem_we, 0);
    step();
    check("er_release", cpu_rdy, 1);
    check("er_stall", stall_count, 17);
    check("er_mem_402", mem[12'h402], 8'h5A);
    check("er_mem_403", mem[12'h403], 8'h00);

    // Reset mid-tenure during the second transfer.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0500; dma_dout = 8'hC3;
    w = 0;
    #1;
    while (!dma_gnt && w < 20) begin
      step();
      w++;
    end
    check("rm_wait", w, 4);
    step();
    dma_addr = 16'h0501;
    #2;
    reset = 1'b1;
    #1;
    check("rm_gnt", dma_gnt, 0);
    check("rm_rdy", cpu_rdy, 1);
    check("rm_ack", dma_ack, 0);
    check("rm_stall", stall_count, 0);
    check("rm_we", mem_we, 0);
    step();
    check("rm_mem_500", mem[12'h500], 8'hC3);
    check("rm_mem_501", mem[12'h501], 8'h00);
    dma_req = 1'b0;
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single memory bus between cpu_core (primary requester) and a DMA/loader port (secondary requester).
- The CPU owns the bus by default.
- DMA requests are granted after a bounded CPU run. The CPU is frozen through its RDY input while DMA holds the bus.
- The block sits between cpu_core, the DMA engine and the ROM/RAM array.
- Memory read is combinational on mem_addr; memory write commits on the rising clk edge when mem_we=1.

Parameters:
ADDR_W, 16, address width of all ports.
DATA_W, 8, data width of all ports.
MAX_CPU_BURST, 4, minimum CPU-owned cycles between DMA tenures while DMA is waiting (legal range >=1).
DMA_MAX_LEN, 8, maximum DMA transfers per tenure (legal range >=1).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
cpu_addr  in  ADDR_W  CPU address.
cpu_dout  in  DATA_W  CPU write data.
cpu_we  in  1  CPU write strobe.
cpu_din  out  DATA_W  read data to CPU (= mem_din).
cpu_rdy  out  1  CPU may advance; 0 = CPU holds addr/we/dout.
dma_req  in  1  DMA transfer request, level; addr/we/dout valid while high.
dma_addr  in  ADDR_W  DMA address.
dma_dout  in  DATA_W  DMA write data.
dma_we  in  1  DMA write strobe.
dma_gnt  out  1  DMA owns the bus.
dma_ack  out  1  DMA transfer completes at the end of this cycle.
dma_din  out  DATA_W  read data to DMA (= mem_din).
mem_addr  out  ADDR_W  memory address.
mem_dout  out  DATA_W  memory write data.
mem_we  out  1  memory write enable.
mem_din  in  DATA_W  memory read data.
stall_count  out  16  debug: total cycles with cpu_rdy=0.

Behaviour:
- Two-state FSM (state register): CPU_OWN, DMA_OWN. Reset value is CPU_OWN.
- Decoded outputs:
  - cpu_rdy = (state==CPU_OWN).
  - dma_gnt = (state==DMA_OWN).
  - dma_ack = dma_gnt & dma_req.
- Bus mux:
  - In CPU_OWN, mem_addr/mem_dout/mem_we = cpu_addr/cpu_dout/cpu_we.
  - In DMA_OWN, mem_addr/mem_dout = dma_addr/dma_dout and mem_we = dma_we & dma_req.
  - A non-owner's we never reaches memory.
- Read path: cpu_din and dma_din are both tied to mem_din combinationally; each is meaningful only in its owner's cycles. Read latency is 0 cycles, write latency 1 edge.
- starve_cnt (0..MAX_CPU_BURST-1):
  - In CPU_OWN with dma_req=1, increments each cycle and saturates at MAX_CPU_BURST-1.
  - Cleared when dma_req=0 and on entering DMA_OWN.
- CPU_OWN -> DMA_OWN when dma_req=1, starve_cnt==MAX_CPU_BURST-1 and cpu_we=0.
  - A CPU write cycle is never preempted; the transition waits for the first non-write cycle.
  - Net effect: DMA waits at least MAX_CPU_BURST CPU cycles after dma_req rises.
- dma_len (0..DMA_MAX_LEN-1): increments on each dma_ack; cleared on entering DMA_OWN.
- DMA_OWN -> CPU_OWN when either:
  - dma_req=0 (no transfer that cycle, mem_we=0), or
  - dma_ack=1 and dma_len==DMA_MAX_LEN-1 (last transfer of the tenure completes, then the bus is released).
- Fairness: after a capped tenure, a still-asserted dma_req restarts starve_cnt from 0, so the CPU always gets MAX_CPU_BURST cycles between tenures.
- stall_count: +1 on every clock with state==DMA_OWN; wraps 0xFFFF -> 0x0000; reset to 0.
- Reset asserted mid-tenure: state=CPU_OWN, counters=0 and stall_count=0 immediately (asynchronous). dma_gnt/dma_ack fall in the same instant, so no partial write is issued after reset.
- Reset values: cpu_rdy=1, dma_gnt=0, dma_ack=0, stall_count=0. mem_* follow the CPU inputs.
- Simultaneous events:
  - dma_req falling in the same cycle the limit is reached: no transition, starve_cnt clears.
  - MAX_CPU_BURST=1: DMA is granted the cycle after the first non-write cycle with dma_req=1.

Test Plan:
- Idle DMA: ROM program LDA #3 / ADC #4 running, dma_req=0 for 200 cycles -> cpu_rdy constantly 1, mem_addr==cpu_addr every cycle, stall_count=0, A ends at 0x07.
- Grant latency: MAX_CPU_BURST=4, dma_req rises before edge N with cpu_we=0 -> dma_gnt=1 in cycle N+4, cpu_rdy=0 in that same cycle, mem_addr==dma_addr.
- Capped tenure: DMA_MAX_LEN=8, dma_req held high writing 0xA5 to 0x0200..0x0209 -> exactly 8 acks (0x0200..0x0207 written), then 4 CPU cycles, then second tenure; stall_count=10 after 0x0209.
- Write protection: dma_req with starve_cnt saturated while cpu_we=1 for 2 cycles -> grant delayed exactly 2 cycles; the CPU write to 0x0010 lands; no dma_we reaches memory during CPU_OWN.
- Early release: dma_req drops after 3 acks -> state returns to CPU_OWN the cycle after dma_req falls; mem_we=0 in that idle DMA cycle; stall_count +4.
- Reset mid-tenure: assert reset between edges during the 2nd DMA transfer -> dma_gnt=0 and cpu_rdy=1 before the next edge, stall_count=0, no memory write at that edge.
